// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared lamp encodings, fault codes and per-approach check flags for the
// traffic conflict monitor.
// Contents: RED/YELLOW/GREEN, F_NONE..F_SHORT_HG, lamp_flags_t, lamp helpers.
package tlc_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_BAD_ENC  = 3'd1;
  localparam logic [2:0] F_CONFLICT = 3'd2;
  localparam logic [2:0] F_BAD_SEQ  = 3'd3;
  localparam logic [2:0] F_SHORT_Y  = 3'd4;
  localparam logic [2:0] F_LONG_CG  = 3'd5;
  localparam logic [2:0] F_SHORT_HG = 3'd6;

  // Per-approach results handed from lamp_seq_checker to the top level.
  typedef struct packed {
    logic enc_err;          // current sample is not a legal lamp code
    logic seq_err;          // illegal change between previous and current sample
    logic y_short;          // yellow -> red after too short a yellow
    logic is_green;         // current sample is GREEN
    logic is_yellow;        // current sample is YELLOW
    logic green_to_yellow;  // green -> yellow change this cycle
    logic steady;           // current sample equals previous one (checks armed)
  } lamp_flags_t;

  function automatic logic lamp_valid(input logic [2:0] l);
    return (l == RED) || (l == YELLOW) || (l == GREEN);
  endfunction

  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == RED)    && (cur == GREEN))  ||
           ((prev == GREEN)  && (cur == YELLOW)) ||
           ((prev == YELLOW) && (cur == RED));
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp observation and fault reporting bundle of the traffic conflict monitor.
// master: controller/lamp side (drives lamps and clear_fault, sees fault outputs);
// slave: the monitor itself.
interface traffic_conflict_monitor_if;
  logic [2:0] highway_light;
  logic [2:0] country_light;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_red;
  logic [7:0] fault_count;

  modport master (
    output highway_light, country_light, clear_fault,
    input  fault, fault_code, flash_red, fault_count
  );

  modport slave (
    input  highway_light, country_light, clear_fault,
    output fault, fault_code, flash_red, fault_count
  );
endinterface

// File: rtl/traffic_conflict_monitor_lamp_seq_checker.sv
// One-approach lamp tracker: samples the lamp bus (s), keeps the previous
// sample (p) and the dwell count of p, and flags encoding/sequence problems.
// Ports: clk, rst_bar, light (lamp bus) -> flags (lamp_flags_t), run (dwell of p).
module lamp_seq_checker
  import tlc_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_YELLOW = 250
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic [2:0]       light,
  output lamp_flags_t      flags,
  output logic [CNT_W-1:0] run
);

  localparam logic [CNT_W-1:0] MIN_Y_C = CNT_W'(MIN_YELLOW);

  logic [2:0]       s_q, s_d;
  logic [2:0]       p_q, p_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             s_vld_q, s_vld_d;   // s holds a real sample
  logic             first_q, first_d;   // p does not yet hold a real sample

  always_comb begin
    s_d     = light;
    p_d     = s_q;
    s_vld_d = 1'b1;
    // Stays set through the first sampling edge so that the reset value
    // shifted into p is never compared against a real sample.
    first_d = ~s_vld_q;
    // run counts how long p's value has been held, so on a transition edge
    // it still describes the state being left.
    if (first_q || (s_q != p_q)) begin
      run_d = CNT_W'(1);
    end else if (&run_q) begin
      run_d = run_q;
    end else begin
      run_d = run_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      s_q     <= 3'b000;
      p_q     <= 3'b000;
      run_q   <= '0;
      s_vld_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      s_q     <= s_d;
      p_q     <= p_d;
      run_q   <= run_d;
      s_vld_q <= s_vld_d;
      first_q <= first_d;
    end
  end

  logic armed;
  logic moved;

  always_comb begin
    armed = ~first_q && lamp_valid(s_q) && lamp_valid(p_q);
    moved = (s_q != p_q);

    flags.enc_err         = s_vld_q && !lamp_valid(s_q);
    flags.seq_err         = armed && moved && !legal_step(p_q, s_q);
    flags.y_short         = armed && (p_q == YELLOW) && (s_q == RED) && (run_q < MIN_Y_C);
    flags.is_green        = (s_q == GREEN);
    flags.is_yellow       = (s_q == YELLOW);
    flags.green_to_yellow = armed && (p_q == GREEN) && (s_q == YELLOW);
    flags.steady          = armed && !moved;
  end

  assign run = run_q;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor on the highway/country lamp buses: latches the first fault
// code, drives a flashing-red override and counts fault events.
// Ports: clk, rst_bar, mon (slave modport: lamps + clear_fault in, fault/code/flash/count out).
module traffic_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW  = 250,
  parameter int MIN_GREEN_H = 6000,
  parameter int MAX_GREEN_C = 1500,
  parameter int FLASH_HALF  = 25,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_bar,
  traffic_conflict_monitor_if.slave    mon
);

  localparam logic [CNT_W-1:0] MIN_GH_C   = CNT_W'(MIN_GREEN_H);
  localparam logic [CNT_W-1:0] MAX_GC_C   = CNT_W'(MAX_GREEN_C);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  // Index 0 = highway, 1 = country.
  lamp_flags_t      flags [2];
  logic [CNT_W-1:0] run_h, run_c;

  lamp_seq_checker #(.CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW)) u_hwy (
    .clk(clk), .rst_bar(rst_bar), .light(mon.highway_light), .flags(flags[0]), .run(run_h)
  );

  lamp_seq_checker #(.CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW)) u_cty (
    .clk(clk), .rst_bar(rst_bar), .light(mon.country_light), .flags(flags[1]), .run(run_c)
  );

  logic       conflict, long_cg, short_hg;
  logic [2:0] code;

  always_comb begin
    // Non-red on both sides; an undecodable lamp is caught by BAD_ENC first.
    conflict = (flags[0].is_green || flags[0].is_yellow) &&
               (flags[1].is_green || flags[1].is_yellow);
    // run_c only describes the current green once p is green as well; at
    // the red->green edge it still holds the length of the preceding red.
    long_cg  = flags[1].is_green && flags[1].steady && (run_c > MAX_GC_C);
    short_hg = flags[0].green_to_yellow && (run_h < MIN_GH_C);

    code = F_NONE;
    if (flags[0].enc_err || flags[1].enc_err) begin
      code = F_BAD_ENC;
    end else if (conflict) begin
      code = F_CONFLICT;
    end else if (flags[0].seq_err || flags[1].seq_err) begin
      code = F_BAD_SEQ;
    end else if (flags[0].y_short || flags[1].y_short) begin
      code = F_SHORT_Y;
    end else if (long_cg) begin
      code = F_LONG_CG;
    end else if (short_hg) begin
      code = F_SHORT_HG;
    end
  end

  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic             flash_q, flash_d;
  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [7:0]       fault_count_q, fault_count_d;

  always_comb begin
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    flash_d       = flash_q;
    flash_cnt_d   = flash_cnt_q;
    fault_count_d = fault_count_q;

    if (!fault_q) begin
      if (code != F_NONE) begin
        fault_d      = 1'b1;
        fault_code_d = code;
        flash_d      = 1'b1;
        flash_cnt_d  = '0;
        if (fault_count_q != 8'hFF) begin
          fault_count_d = fault_count_q + 8'd1;
        end
      end
    end else if (mon.clear_fault && (code == F_NONE)) begin
      fault_d      = 1'b0;
      fault_code_d = F_NONE;
      flash_d      = 1'b0;
      flash_cnt_d  = '0;
    end else if (flash_cnt_q == FLASH_LAST) begin
      flash_cnt_d = '0;
      flash_d     = ~flash_q;
    end else begin
      flash_cnt_d = flash_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      fault_q       <= 1'b0;
      fault_code_q  <= F_NONE;
      flash_q       <= 1'b0;
      flash_cnt_q   <= '0;
      fault_count_q <= 8'd0;
    end else begin
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      flash_q       <= flash_d;
      flash_cnt_q   <= flash_cnt_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign mon.fault       = fault_q;
  assign mon.fault_code  = fault_code_q;
  assign mon.flash_red   = flash_q;
  assign mon.fault_count = fault_count_q;

endmodule
